// File: rtl/interact_pkg.sv
// Shared NoC link types: flit layout, flit type codes and the router channel bundles.
package interact;

    localparam int PAYLOAD_W = 16;
    localparam int DEST_W    = 8;
    localparam int FLIT_W    = PAYLOAD_W + 2;

    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b01;

    typedef struct packed {
        logic              req;
        logic [FLIT_W-1:0] data;
    } channel_forward;

    typedef struct packed {
        logic ack;
    } channel_backward;

    typedef struct packed {
        logic                 first;
        logic                 last;
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_HEAD,
        P_PAYLOAD
    } pkt_state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_SETUP,
        L_FIRE,
        L_WAIT
    } link_state_t;

    function automatic logic [FLIT_W-1:0] make_flit(input logic [1:0] ftype,
                                                    input logic [FLIT_W-3:0] body);
        return {ftype, body};
    endfunction

endpackage

// File: rtl/ni_tx_if.sv
// Flit hand-off between the packet framer and the link transmitter.
interface ni_tx_if;
    import interact::*;

    logic              valid;
    logic              ready;
    logic [FLIT_W-1:0] flit;

    modport master (output valid, output flit, input ready);
    modport slave  (input valid, input flit, output ready);

endinterface

// File: rtl/ni_link_tx.sv
// Two-phase bundled-data link transmitter with a multi-flop ack synchronizer.
module ni_link_tx
    import interact::*;
#(
    parameter int ACK_SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            preset,
    ni_tx_if.slave          flit_in,
    output channel_forward  chan_out_f,
    input  channel_backward chan_out_b
);

    logic              ack_stage [ACK_SYNC_STAGES];
    logic              ack_sync;
    logic              req_reg;
    logic [FLIT_W-1:0] data_reg;
    link_state_t       state_reg;

    // ack comes from another timing island; nothing may look at it before the last stage
    for (genvar gi = 0; gi < ACK_SYNC_STAGES; gi++) begin : g_ack_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (preset) ack_stage[gi] <= 1'b0;
                else        ack_stage[gi] <= chan_out_b.ack;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (preset) ack_stage[gi] <= 1'b0;
                else        ack_stage[gi] <= ack_stage[gi-1];
            end
        end
    end

    assign ack_sync      = ack_stage[ACK_SYNC_STAGES-1];
    assign flit_in.ready = (state_reg == L_IDLE) || (state_reg == L_SETUP);
    assign chan_out_f    = '{req: req_reg, data: data_reg};

    // Data is captured on entry to FIRE and req flips one edge later, so the
    // bundle is settled a full cycle before the receiver can see the transition.
    always_ff @(posedge clk) begin
        if (preset) begin
            state_reg <= L_IDLE;
            req_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            unique case (state_reg)
                L_IDLE, L_SETUP: begin
                    if (flit_in.valid) begin
                        data_reg  <= flit_in.flit;
                        state_reg <= L_FIRE;
                    end else begin
                        state_reg <= L_IDLE;
                    end
                end
                L_FIRE: begin
                    req_reg   <= !req_reg;
                    state_reg <= L_WAIT;
                end
                L_WAIT: begin
                    if (ack_sync == req_reg)
                        state_reg <= flit_in.valid ? L_SETUP : L_IDLE;
                end
                default: state_reg <= L_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ni_tx.sv
// Network-interface transmit side: payload FIFO plus packet framer feeding the link transmitter.
module ni_tx
    import interact::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int ACK_SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 preset,
    input  logic                 core_valid,
    output logic                 core_ready,
    input  logic [PAYLOAD_W-1:0] core_data,
    input  logic [DEST_W-1:0]    core_dest,
    input  logic                 core_last,
    output channel_forward       chan_out_f,
    input  channel_backward      chan_out_b
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    fifo_entry_t      mem [FIFO_DEPTH];
    fifo_entry_t      head;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             in_pkt_reg;
    pkt_state_t       pkt_state_reg;
    logic             push;
    logic             pop;
    logic             empty;
    logic             take;

    ni_tx_if flit_bus ();

    // Full stays full for the cycle even if a pop happens: ready looks only at the stored count.
    assign core_ready = !preset && (count_reg < DEPTH_CNT);
    assign push       = core_valid && core_ready;
    assign empty      = (count_reg == '0);
    assign head       = mem[rd_ptr_reg];
    assign take       = flit_bus.valid && flit_bus.ready;
    assign pop        = take && (pkt_state_reg == P_PAYLOAD);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= '{first: !in_pkt_reg, last: core_last,
                                 dest: core_dest, data: core_data};
    end

    // HEAD is built from the first entry without popping it; that entry later leaves as BODY/TAIL.
    always_comb begin
        flit_bus.valid = 1'b0;
        flit_bus.flit  = '0;
        unique case (pkt_state_reg)
            P_IDLE, P_HEAD: begin
                if (!empty && head.first) begin
                    flit_bus.valid = 1'b1;
                    flit_bus.flit  = make_flit(FT_HEAD, (FLIT_W-2)'(head.dest));
                end
            end
            P_PAYLOAD: begin
                if (!empty) begin
                    flit_bus.valid = 1'b1;
                    flit_bus.flit  = make_flit(head.last ? FT_TAIL : FT_BODY, head.data);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            in_pkt_reg    <= 1'b0;
            pkt_state_reg <= P_IDLE;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                in_pkt_reg <= !core_last;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;

            unique case (pkt_state_reg)
                P_IDLE: begin
                    if (flit_bus.valid)
                        pkt_state_reg <= flit_bus.ready ? P_PAYLOAD : P_HEAD;
                end
                P_HEAD: begin
                    if (take)
                        pkt_state_reg <= P_PAYLOAD;
                end
                P_PAYLOAD: begin
                    if (pop && head.last)
                        pkt_state_reg <= P_IDLE;
                end
                default: pkt_state_reg <= P_IDLE;
            endcase
        end
    end

    ni_link_tx #(
        .ACK_SYNC_STAGES(ACK_SYNC_STAGES)
    ) u_link (
        .clk       (clk),
        .preset    (preset),
        .flit_in   (flit_bus),
        .chan_out_f(chan_out_f),
        .chan_out_b(chan_out_b)
    );

endmodule

// File: tb/tb_ni_tx.sv
// Scoreboard bench for ni_tx: expected flits queued at stimulus time, a monitor checks each req transition.
module tb_ni_tx;
    import interact::*;

    localparam int FIFO_DEPTH      = 4;
    localparam int ACK_SYNC_STAGES = 2;
    localparam int BIG             = 1 << 30;

    logic                 clk = 1'b0;
    logic                 preset = 1'b1;
    logic                 core_valid = 1'b0;
    logic                 core_ready;
    logic [PAYLOAD_W-1:0] core_data = '0;
    logic [DEST_W-1:0]    core_dest = '0;
    logic                 core_last = 1'b0;
    channel_forward       chan_out_f;
    channel_backward      chan_out_b;
    logic                 ack_lvl = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [FLIT_W-1:0] exp_q [$];
    int n_toggles = 0;
    int ack_chg_cyc = -100;

    int ack_min = 1;
    int ack_max = 1;
    int ack_credits = BIG;
    int spur_len = 0;

    assign chan_out_b = '{ack: ack_lvl};

    ni_tx #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .ACK_SYNC_STAGES(ACK_SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .preset    (preset),
        .core_valid(core_valid),
        .core_ready(core_ready),
        .core_data (core_data),
        .core_dest (core_dest),
        .core_last (core_last),
        .chan_out_f(chan_out_f),
        .chan_out_b(chan_out_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every req transition is one flit leaving the interface.
    initial begin
        logic              prev_req;
        logic [FLIT_W-1:0] prev_data;
        logic [FLIT_W-1:0] exp;
        prev_req  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (preset) begin
                prev_req  = 1'b0;
                prev_data = '0;
            end else begin
                if (chan_out_f.req !== prev_req) begin
                    n_toggles++;
                    check("ack_done_before_toggle", 32'(ack_lvl), 32'(prev_req));
                    check("ack_synced_before_toggle", 32'((cyc - ack_chg_cyc) > ACK_SYNC_STAGES), 32'd1);
                    check("data_setup_before_toggle", 32'(chan_out_f.data), 32'(prev_data));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL flit_unexpected: got 0x%0h expected none (cycle %0d)",
                                 chan_out_f.data, cyc);
                    end else begin
                        exp = exp_q.pop_front();
                        $display("flit 0x%05h expected 0x%05h at cycle %0d", chan_out_f.data, exp, cyc);
                        check("flit", 32'(chan_out_f.data), 32'(exp));
                    end
                end else if (chan_out_f.req !== ack_lvl) begin
                    check("data_hold_in_flight", 32'(chan_out_f.data), 32'(prev_data));
                end
                prev_req  = chan_out_f.req;
                prev_data = chan_out_f.data;
            end
        end
    end

    // Router-side responder: echoes req after a random delay, or issues a spurious pulse.
    initial begin
        int wait_cnt;
        wait_cnt = -1;
        forever begin
            @(negedge clk);
            if (preset) begin
                ack_lvl  = 1'b0;
                wait_cnt = -1;
            end else if (spur_len > 0) begin
                spur_len--;
                ack_lvl     = (spur_len == 0) ? chan_out_f.req : ~chan_out_f.req;
                ack_chg_cyc = cyc;
            end else if (chan_out_f.req !== ack_lvl) begin
                if (wait_cnt < 0) wait_cnt = $urandom_range(ack_max, ack_min);
                else if (wait_cnt > 0) wait_cnt--;
                if (wait_cnt == 0 && ack_credits > 0) begin
                    ack_lvl     = chan_out_f.req;
                    ack_credits--;
                    ack_chg_cyc = cyc;
                    wait_cnt    = -1;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_beat(input logic [DEST_W-1:0] d, input logic [PAYLOAD_W-1:0] x,
                             input logic last, output int acc_cyc);
        logic rdy;
        core_valid = 1'b1;
        core_dest  = d;
        core_data  = x;
        core_last  = last;
        acc_cyc    = -1;
        for (int t = 0; t < 3000; t++) begin
            rdy = core_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                acc_cyc = cyc;
                break;
            end
        end
        core_valid = 1'b0;
        if (acc_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: got no accept expected accept");
        end
    endtask

    task automatic send_packet(input logic [DEST_W-1:0] d, input int n, input int gap_max);
        logic [PAYLOAD_W-1:0] x;
        int acc;
        logic [PAYLOAD_W-1:0] beats [$];
        exp_q.push_back({2'b10, {(PAYLOAD_W-DEST_W){1'b0}}, d});
        for (int i = 0; i < n; i++) begin
            x = PAYLOAD_W'($urandom);
            beats.push_back(x);
            exp_q.push_back({(i == n-1) ? 2'b01 : 2'b00, x});
        end
        for (int i = 0; i < n; i++) begin
            send_beat(d, beats[i], i == n-1, acc);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        for (t = 0; t < 5000; t++) begin
            if (exp_q.size() == 0 && chan_out_f.req === ack_lvl) break;
            @(negedge clk);
        end
        repeat (ACK_SYNC_STAGES + 4) @(negedge clk);
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL %s: got %0d flits outstanding expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        int acc;
        int t0;
        logic              req0;
        logic [FLIT_W-1:0] data0;

        // reset state
        preset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_core_ready", 32'(core_ready), 32'd0);
        check("rst_req", 32'(chan_out_f.req), 32'd0);
        check("rst_data", 32'(chan_out_f.data), 32'd0);
        preset = 1'b0;
        #1;
        check("ready_after_rst", 32'(core_ready), 32'd1);
        @(negedge clk);

        // single-beat packet, ack echoed after 3 cycles, with latency probe
        ack_min = 3;
        ack_max = 3;
        t0 = n_toggles;
        exp_q.push_back(18'h20005);
        exp_q.push_back(18'h100A5);
        send_beat(8'h05, 16'h00A5, 1'b1, acc);
        @(negedge clk);
        check("lat_head_data_n1", 32'(chan_out_f.data), 32'h20005);
        check("lat_req_hold_n1", 32'(chan_out_f.req), 32'd0);
        @(negedge clk);
        check("lat_req_toggle_n2", 32'(chan_out_f.req), 32'd1);
        wait_drain("drain_1beat");
        check("one_beat_toggles", 32'(n_toggles - t0), 32'd2);
        check("one_beat_req_final", 32'(chan_out_f.req), 32'd0);

        // spurious ack pulse while idle
        req0  = chan_out_f.req;
        data0 = chan_out_f.data;
        t0    = n_toggles;
        spur_len = 4;
        repeat (12) @(negedge clk);
        check("spur_req", 32'(chan_out_f.req), 32'(req0));
        check("spur_data", 32'(chan_out_f.data), 32'(data0));
        check("spur_toggles", 32'(n_toggles - t0), 32'd0);

        // four beats with ack withheld: FIFO fills behind the HEAD in flight
        ack_credits = 0;
        t0 = n_toggles;
        send_packet(8'h3C, 4, 0);
        check("full_core_ready", 32'(core_ready), 32'd0);
        check("full_req_head", 32'(chan_out_f.req), 32'd1);
        check("full_head_only", 32'(n_toggles - t0), 32'd1);
        repeat (6) @(negedge clk);
        check("stall_no_flit", 32'(n_toggles - t0), 32'd1);
        ack_min = 1;
        ack_max = 4;
        ack_credits = BIG;
        wait_drain("drain_4beat");
        check("four_beat_toggles", 32'(n_toggles - t0), 32'd5);

        // reset while BODY is waiting for its ack
        ack_min = 2;
        ack_max = 2;
        ack_credits = 1;
        t0 = n_toggles;
        send_packet(8'h21, 3, 0);
        for (int t = 0; t < 200 && (n_toggles - t0) < 2; t++) @(negedge clk);
        check("body_in_flight", 32'(n_toggles - t0), 32'd2);
        preset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 32'(chan_out_f.req), 32'd0);
        check("mid_rst_core_ready", 32'(core_ready), 32'd0);
        exp_q.delete();
        ack_credits = BIG;
        preset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(core_ready), 32'd1);
        check("post_rst_req", 32'(chan_out_f.req), 32'd0);
        send_packet(8'h47, 2, 0);
        wait_drain("drain_after_rst");

        // random back-to-back packets with random ack delay and core stalls
        ack_min = 1;
        ack_max = 20;
        for (int p = 0; p < 40; p++) begin
            send_packet(DEST_W'($urandom), $urandom_range(6, 1), ($urandom_range(3, 0) == 0) ? 3 : 0);
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(5, 0)) @(negedge clk);
        end
        wait_drain("drain_random");
        check("random_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ni_tx.md
NI_TX -- requirements
Module: ni_tx

Interface
REQ-001 The module SHALL provide parameter FIFO_DEPTH, default 4, the payload FIFO entry count (power of two, ≥2).
REQ-002 The module SHALL provide parameter ACK_SYNC_STAGES, default 2, the flop count on the incoming ack.
REQ-003 The module SHALL provide port clk, input, 1 bit, the single clock.
REQ-004 The module SHALL provide port preset, input, 1 bit, reset; synchronous, active-high.
REQ-005 The module SHALL provide port core_valid, input, 1 bit, payload beat offered.
REQ-006 The module SHALL provide port core_ready, output, 1 bit, beat accepted when valid&ready at rising clk.
REQ-007 The module SHALL provide port core_data, input, PAYLOAD_W bits, payload beat.
REQ-008 The module SHALL provide port core_dest, input, DEST_W bits, destination {x,y}, sampled on first beat of a packet.
REQ-009 The module SHALL provide port core_last, input, 1 bit, final beat of packet.
REQ-010 The module SHALL provide port chan_out_f, output, channel_forward, {req, data[FLIT_W]} to router resource input latch.
REQ-011 The module SHALL provide port chan_out_b, input, channel_backward, {ack} from router resource input latch.

Function
REQ-012 Flit format SHALL be {type[1:0], body[FLIT_W-3:0]}: HEAD=2'b10 carries zero-extended core_dest; BODY=2'b00 and TAIL=2'b01 carry core_data.
REQ-013 Each packet SHALL be emitted as one HEAD, then one BODY per non-last beat, then one TAIL for the core_last beat; a 1-beat packet is HEAD+TAIL.
REQ-014 The FIFO SHALL store {first, last, dest, data}; core_ready = (count < FIFO_DEPTH), derived from registered count only.
REQ-015 At full, a simultaneous pop SHALL NOT allow a same-cycle push; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 The packet FSM SHALL have states P_IDLE, P_HEAD, P_PAYLOAD: P_IDLE→P_HEAD when FIFO non-empty; P_HEAD→P_PAYLOAD after HEAD handed to link; P_PAYLOAD pops one entry per flit; it returns to P_IDLE after TAIL handed off.
REQ-017 Link handshake SHALL be 2-phase bundled data: one flit per req transition; a flit is complete when ack_sync == req.
REQ-018 The link FSM SHALL have states L_IDLE, L_SETUP, L_FIRE, L_WAIT: SETUP loads data register; FIRE toggles req on the next edge; WAIT holds until ack_sync == req, then → L_IDLE, or → L_SETUP the same cycle if another flit is pending.
REQ-019 chan_out_f.data SHALL be stable ≥1 full clk cycle before and throughout any req toggle until the matching ack is synchronized.
REQ-020 chan_out_b.ack SHALL pass through ACK_SYNC_STAGES flops before any use; no other asynchronous input exists.
REQ-021 Latency SHALL be: beat accepted at edge N into empty FIFO with idle link → HEAD data at N+1, HEAD req toggle at N+2.
REQ-022 An ack transition when ack_sync already equals req (spurious) SHALL be ignored, with no req change.
REQ-023 core_valid dropping mid-packet SHALL stall emission with req held; no flit is fabricated.

Reset
REQ-024 During preset: req=0, data=0, ack sync flops=0, FIFO empty, core_ready=0, both FSMs idle.
REQ-025 First cycle after preset deasserts: core_ready=1.
REQ-026 preset mid-packet SHALL discard FIFO contents and any in-flight flit; router shares preset, so req/ack levels realign to 0.

Structure
REQ-027 FLIT_W, PAYLOAD_W, DEST_W, flit-type constants, channel_forward/channel_backward SHALL live in package interact.
REQ-028 The link FSM and ack synchronizer SHALL be sub-module ni_link_tx; FIFO and packet FSM stay in ni_tx.

Verification
REQ-029 1-beat packet dest=0x5, data=0xA5 with ack echoing req after 3 cycles → HEAD(type 10, body 0x5) then TAIL(type 01, body 0xA5); req toggles 0→1→0.
REQ-030 4-beat packet with ack withheld → core_ready=0 after 4 accepted beats and HEAD in flight; release ack → BODY,BODY,BODY,TAIL in order.
REQ-031 Idle link, single beat accepted at edge N → data valid N+1, req toggle N+2.
REQ-032 Spurious ack pulse while idle → no req change, no data change.
REQ-033 preset asserted while waiting on BODY ack → next cycle req=0, FIFO empty; a new packet then starts with HEAD.
REQ-034 Random back-to-back packets, random ack delay 1-20 cycles → scoreboard matches every flit; no req toggle while ack_sync != req.
